conv_layer_sched: RTL and testbench

Sequencer for the combinational 3x3 convolution datapath of layer 1. It walks every (channel, row, column) output position and drives the window/weight-select coordinates into the shared MAC unit. It captures the unit's 24-bit result into a ready/valid output register tagged with the flat output address. It sits between the layer-level start/done control and the feature-map writer, and replaces free-running address generation with back-pressure-aware scheduling.

---
 rtl/conv_layer_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sched.sv
// ---------------------------------------------------------------------------
// conv_layer_sched
//
// Sequencer for the layer-1 3x3 convolution datapath. It walks every
// (channel, row, column) output position in that order (column innermost),
// presents the window/kernel coordinates to the shared combinational MAC unit,
// and captures the MAC result into a ready/valid output register. Each result
// is tagged with its flat output address. Back-pressure from the feature-map
// writer freezes the walk, so the win_* coordinates stay stable while the
// consumer stalls.
//
// Ports:
//   clk       - clock
//   rst_n     - synchronous, active-low reset
//   start     - begin one full layer pass (only honoured in IDLE)
//   abort     - synchronous cancel of the current pass, any state
//   win_row   - top row of current input window (= output row)
//   win_col   - left column of current input window (= output column)
//   win_chan  - kernel/channel select for the weight mux
//   res_in    - signed MAC result for the current win_* coordinates
//   out_valid - out_data/out_addr hold a result
//   out_ready - consumer accepts the beat when out_valid && out_ready
//   out_data  - captured signed result (full 24 bits)
//   out_addr  - flat address chan*OUT_H*OUT_W + row*OUT_W + col
//   busy      - high in any state other than IDLE
//   done      - one-cycle pulse after the last beat is accepted
//
// Build option:
//   CONV_SCHED_RELU_EN - when defined, negative MAC results are clamped to
//                        zero as they are captured (fused ReLU, no latency).
// ---------------------------------------------------------------------------
module conv_layer_sched #(
    parameter int OUT_H  = 14,
    parameter int OUT_W  = 13,
    parameter int CHAN   = 10,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic [7:0]        win_chan,
    input  logic [23:0]       res_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [23:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_H * OUT_W * CHAN - 1);
    localparam logic [7:0]        COL_LAST = 8'(OUT_W - 1);
    localparam logic [7:0]        ROW_LAST = 8'(OUT_H - 1);

    // Value written into the output register at capture time.
    function automatic logic [23:0] out_stage(input logic [23:0] r);
`ifdef CONV_SCHED_RELU_EN
        if (r[23]) begin
            out_stage = 24'd0;
        end else begin
            out_stage = r;
        end
`else
        out_stage = r;
`endif
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          row_q, row_d;
    logic [7:0]          col_q, col_d;
    logic [7:0]          chan_q, chan_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    logic [23:0]         out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cap_s;
    logic                hs_s;

    // Next-state and datapath register computation.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        chan_d      = chan_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        done_d      = 1'b0;

        // The output slot is free when empty or being drained this cycle.
        cap_s = !out_valid_q || out_ready;
        hs_s  = out_valid_q && out_ready;

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                row_d       = 8'd0;
                col_d       = 8'd0;
                chan_d      = 8'd0;
                idx_d       = '0;
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (cap_s) begin
                    out_data_d  = out_stage(res_in);
                    out_addr_d  = idx_q;
                    out_valid_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Last position captured: counters freeze on it.
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                        if (col_q == COL_LAST) begin
                            col_d = 8'd0;
                            if (row_q == ROW_LAST) begin
                                row_d  = 8'd0;
                                chan_d = chan_q + 8'd1;
                            end else begin
                                row_d = row_q + 8'd1;
                            end
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end
                end else begin
                    // Stalled: everything holds so win_* stay stable.
                    out_valid_d = out_valid_q;
                end
            end

            ST_DRAIN: begin
                if (hs_s) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort wins over start and over any same-cycle handshake/capture.
        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            row_d       = 8'd0;
            col_d       = 8'd0;
            chan_d      = 8'd0;
            idx_d       = '0;
            done_d      = 1'b0;
        end else begin
            done_d = done_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            chan_q      <= 8'd0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 24'd0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            chan_q      <= chan_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign win_row   = row_q;
    assign win_col   = col_q;
    assign win_chan  = chan_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_sched
//
// Self-checking bench for conv_layer_sched. A behavioural MAC model drives
// res_in from the window coordinates; a scoreboard predicts every accepted
// beat (address and data) from the flat index with plain division, and the
// expected window coordinates from the number of beats captured so far.
// ---------------------------------------------------------------------------
module tb_conv_layer_sched;

    localparam int H  = 14;
    localparam int W  = 13;
    localparam int C  = 10;
    localparam int AW = 11;
    localparam int N  = H * W * C;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [7:0]    win_row;
    logic [7:0]    win_col;
    logic [7:0]    win_chan;
    logic [23:0]   res_in;
    logic          out_valid;
    logic          out_ready;
    logic [23:0]   out_data;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;

    int total;
    int bad;
    int cyc;
    int exp_addr;
    int done_cnt;

    conv_layer_sched #(
        .OUT_H (H),
        .OUT_W (W),
        .CHAN  (C),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .win_row  (win_row),
        .win_col  (win_col),
        .win_chan (win_chan),
        .res_in   (res_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: a distinct signed value per window position.
    function automatic logic [23:0] mac_f(input int r, input int c, input int ch);
        if (r == 0 && c == 0 && ch == 0) return 24'hFFFFFB;
        if (r == 0 && c == 1 && ch == 0) return 24'd7;
        return 24'(ch * 70001 + r * 313 + c * 7 - 400000);
    endfunction

    assign res_in = mac_f(int'(win_row), int'(win_col), int'(win_chan));

    function automatic logic [23:0] exp_data(input int a);
        logic [23:0] v;
        v = mac_f((a % (H * W)) / W, a % W, a / (H * W));
`ifdef CONV_SCHED_RELU_EN
        if (v[23]) v = 24'd0;
`endif
        return v;
    endfunction

    function automatic logic [31:0] win_of(input int a);
        return {8'd0, 8'((a % (H * W)) / W), 8'(a % W), 8'(a / (H * W))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: note the beat (if any) accepted at this edge, then score it.
    task automatic tick();
        bit            acc;
        logic [AW-1:0] a;
        logic [23:0]   d;
        int            idx;
        acc = out_valid && out_ready;
        a   = out_addr;
        d   = out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (acc && rst_n) begin
            chk("beat_addr", 32'(a), 32'(exp_addr));
            chk("beat_data", 32'(d), 32'(exp_data(exp_addr)));
            exp_addr++;
        end
        if (done) done_cnt++;
        if (busy) begin
            idx = exp_addr + (out_valid ? 1 : 0);
            if (idx > N - 1) idx = N - 1;
            chk("win_coord", {8'd0, win_row, win_col, win_chan}, win_of(idx));
        end
    endtask

    task automatic kick();
        exp_addr = 0;
        done_cnt = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Run until done, then check the pulse width, return to IDLE and beat count.
    task automatic finish_pass(input int mode, input bit snoise, output int done_cyc);
        int n;
        int hold;
        n        = 0;
        hold     = 0;
        done_cyc = -1;
        while (done_cnt == 0 && n < 20000) begin
            if (mode == 0) out_ready = 1'b1;
            else           out_ready = ($urandom_range(0, 3) != 0);
            if (snoise) start = 1'($urandom_range(0, 1));
            if (snoise && out_valid && int'(out_addr) == N - 1 && hold < 3) begin
                out_ready = 1'b0;
                start     = 1'b1;
                hold++;
            end
            tick();
            n++;
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        start = 1'b0;
        if (done_cnt == 0) chk("pass_timeout", 32'd0, 32'd1);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("beat_count", 32'(exp_addr), 32'(N));
        chk("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    // Full pass with out_ready high, including exact latency and window probes.
    task automatic full_pass_checked();
        int cyc_s;
        int dc;
        int n;
        out_ready = 1'b1;
        kick();
        cyc_s = cyc;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_before_first", 32'(out_valid), 32'd0);
        tick();
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_addr", 32'(out_addr), 32'd0);
`ifdef CONV_SCHED_RELU_EN
        chk("neg_data", 32'(out_data), 32'h0);
`else
        chk("neg_data", 32'(out_data), 32'hFFFFFB);
`endif
        tick();
        chk("pos_data", 32'(out_data), 32'd7);
        n = 0;
        while (int'(out_addr) != 181 && n < 400) begin
            if (int'(out_addr) == 11) chk("win_idx12", {8'd0, win_row, win_col, win_chan}, {8'd0, 8'd0, 8'd12, 8'd0});
            if (int'(out_addr) == 12) chk("win_idx13", {8'd0, win_row, win_col, win_chan}, {8'd0, 8'd1, 8'd0, 8'd0});
            tick();
            n++;
        end
        chk("addr181_reached", 32'(out_addr), 32'd181);
        chk("win_idx182", {8'd0, win_row, win_col, win_chan}, {8'd0, 8'd0, 8'd0, 8'd1});
        finish_pass(0, 1'b0, dc);
        chk("done_latency", 32'(dc - cyc_s), 32'(N + 1));
    endtask

    initial begin
        int n;
        int dc;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        exp_addr  = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_win", {8'd0, win_row, win_col, win_chan}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Scenario 1: full pass at full throughput.
        full_pass_checked();

        // Scenario 2: backpressure after 3 beats, then random ready.
        out_ready = 1'b1;
        kick();
        n = 0;
        while (exp_addr < 3 && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_addr", 32'(out_addr), 32'd3);
            chk("bp_win", {8'd0, win_row, win_col, win_chan}, win_of(4));
        end
        finish_pass(1, 1'b0, dc);

        // Scenario 3: abort while beat 500 is handed over.
        out_ready = 1'b1;
        kick();
        n = 0;
        while (!(out_valid && int'(out_addr) == 500) && n < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        chk("abort_point", 32'(out_addr), 32'd500);
        out_ready = 1'b1;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_beat_seen", 32'(exp_addr), 32'd501);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_over_start", 32'(busy), 32'd0);
        tick();
        chk("abort_start_idle", 32'(busy), 32'd0);
        kick();
        tick();
        chk("restart_addr", 32'(out_addr), 32'd0);
        chk("restart_valid", 32'(out_valid), 32'd1);
        finish_pass(1, 1'b0, dc);

        // Scenario 4: start toggling during RUN and DRAIN is ignored.
        out_ready = 1'b1;
        kick();
        finish_pass(1, 1'b1, dc);

        // Scenario 5: reset mid-run, then a clean full pass.
        out_ready = 1'b1;
        kick();
        for (int i = 0; i < 100; i++) begin
            out_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_addr", 32'(out_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_win", {8'd0, win_row, win_col, win_chan}, 32'd0);
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        tick();
        full_pass_checked();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
